// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions for the 16-bit MIPS front end: widths, fetch defaults
// and the fetch state encoding.
package instruction_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 16;

  typedef logic [INSTR_W-1:0] word_t;

  localparam word_t RESET_PC_DEF  = 16'h0000;
  localparam word_t HALT_WORD_DEF = 16'hFFFF;
  localparam word_t PC_STEP_DEF   = 16'd2;

  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic word_t sat_inc(word_t v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit (master) and
// the instruction memory (slave).
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  word_t imem_rdata;
  logic  imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches 16-bit words over the imem bus and hands
// them to decode with a one-cycle valid strobe until the halt word arrives.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t HALT_WORD = HALT_WORD_DEF,
  parameter word_t PC_STEP   = PC_STEP_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  word_t                     branch_target,
  instruction_fetch_unit_if.master  imem,
  output word_t                     PC,
  output word_t                     IR,
  output logic                      ir_valid,
  output logic                      halted,
  output word_t                     instr_count
);

  fetch_state_e state;
  word_t        fetch_pc;
  logic         started;
  logic         accept;

  // started keeps the request low for the first cycle out of reset
  assign imem.imem_addr = fetch_pc;
  assign imem.imem_req  = started && (state == ST_FETCH) && !stall && !branch_taken;
  assign accept         = imem.imem_req && imem.imem_ready;
  assign halted         = (state == ST_HALTED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_FETCH;
      fetch_pc    <= RESET_PC;
      started     <= 1'b0;
      PC          <= '0;
      IR          <= '0;
      ir_valid    <= 1'b0;
      instr_count <= '0;
    end else begin
      started  <= 1'b1;
      ir_valid <= accept;
      if (state == ST_FETCH) begin
        if (branch_taken) begin
          fetch_pc <= {branch_target[15:1], 1'b0};
        end else if (accept) begin
          IR          <= imem.imem_rdata;
          PC          <= fetch_pc;
          instr_count <= sat_inc(instr_count);
          // the halt word is delivered but fetch_pc stays on it
          if (imem.imem_rdata == HALT_WORD) state    <= ST_HALTED;
          else                              fetch_pc <= fetch_pc + PC_STEP;
        end
      end
    end
  end

endmodule
